uart_rx_fifo: RTL

Parametrised UART receiver with a receive FIFO, error detection and a pop handshake. It replaces the fixed 8N1 receive path that feeds the PET keyboard translator. Consumers such as the key mapper, monitor or loader drain bytes at their own pace, with no single-cycle strobe to catch. All logic runs in the 50 MHz system clock domain.

---
 rtl/uart_rx_fifo.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (mid-bit sampling, optional parity) feeding a circular receive FIFO
// with a valid/ack pop interface and sticky framing, parity and overrun flags.
module uart_rx_fifo #(
    parameter int CLK_DIVIDER = 5208,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          serial_in,
    output logic [DATA_BITS-1:0]          read_data,
    output logic                          read_valid,
    input  logic                          read_ack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_err,
    output logic                          parity_err,
    output logic                          overrun_err,
    input  logic                          err_clear
);

    localparam int CNT_W = $clog2(CLK_DIVIDER);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(CLK_DIVIDER / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD  = CNT_W'(CLK_DIVIDER - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_nxt;
    logic                 sync_meta, line;
    logic [CNT_W-1:0]     tick_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 tc;
    logic                 load_half, load_full, shift_en, par_en, stop_en;
    logic                 parity_ok;
    logic                 frame_evt, parity_evt, good_evt;
    logic                 push_req;
    logic [DATA_BITS-1:0] push_data;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [PTR_W:0]       count_nxt;
    logic [DATA_BITS-1:0] head_nxt;
    logic                 full, do_pop, do_push, overrun_evt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b1;
            line      <= 1'b1;
        end else begin
            sync_meta <= serial_in;
            line      <= sync_meta;
        end
    end

    assign tc = (tick_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_IDLE: if (line) state_nxt = IDLE;
            IDLE:      if (!line) state_nxt = START;
            START:     if (tc) state_nxt = line ? IDLE : DATA;
            DATA:      if (tc && bit_idx == LAST_BIT) state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:       if (tc) state_nxt = STOP;
            STOP:      if (tc) state_nxt = line ? IDLE : WAIT_IDLE;
            default:   state_nxt = WAIT_IDLE;
        endcase
    end

    always_comb begin
        load_half = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stop_en   = 1'b0;
        case (state)
            IDLE:  load_half = !line;
            START: load_full = tc && !line;
            DATA: begin
                shift_en  = tc;
                load_full = tc;
            end
            PAR: begin
                par_en    = tc;
                load_full = tc;
            end
            STOP:  stop_en = tc;
            default: ;
        endcase
    end

    always_comb begin
        parity_ok = 1'b1;
        if (PARITY == 1)      parity_ok = (^shreg) ^ par_bit;
        else if (PARITY == 2) parity_ok = !((^shreg) ^ par_bit);
    end

    assign frame_evt  = stop_en && !line;
    assign parity_evt = stop_en && line && !parity_ok;
    assign good_evt   = stop_en && line && parity_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            push_req  <= 1'b0;
            push_data <= '0;
        end else begin
            if (load_half)      tick_cnt <= HALF_LOAD;
            else if (load_full) tick_cnt <= FULL_LOAD;
            else if (!tc)       tick_cnt <= tick_cnt - CNT_W'(1);

            if (load_half)     bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + BIT_W'(1);

            // Shift in at the MSB so the first (LSB-first) bit ends up in bit 0.
            if (shift_en) shreg <= {line, shreg[DATA_BITS-1:1]};

            if (load_half)   par_bit <= 1'b0;
            else if (par_en) par_bit <= line;

            push_req <= good_evt;
            if (good_evt) push_data <= shreg;
        end
    end

    // FIFO: occupancy alone distinguishes full from empty; pointers wrap naturally.
    assign read_valid  = (fifo_count != '0);
    assign full        = (fifo_count == FULL_COUNT);
    assign do_pop      = read_ack && read_valid;
    assign do_push     = push_req && (!full || do_pop);
    assign overrun_evt = push_req && full && !do_pop;
    assign rd_ptr_nxt  = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    always_comb begin
        count_nxt = fifo_count;
        if (do_push && !do_pop)      count_nxt = fifo_count + (PTR_W + 1)'(1);
        else if (!do_push && do_pop) count_nxt = fifo_count - (PTR_W + 1)'(1);
    end

    // A byte written this clock that becomes the new head bypasses the array.
    always_comb begin
        head_nxt = read_data;
        if (count_nxt != '0) begin
            if (do_push && wr_ptr == rd_ptr_nxt) head_nxt = push_data;
            else                                 head_nxt = mem[rd_ptr_nxt];
        end
    end

    // NOTE: the storage array has no reset; pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            read_data   <= '0;
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr     <= rd_ptr_nxt;
            fifo_count <= count_nxt;
            read_data  <= head_nxt;
            // Set beats clear when both land on the same clock.
            framing_err <= frame_evt   || (framing_err && !err_clear);
            parity_err  <= parity_evt  || (parity_err  && !err_clear);
            overrun_err <= overrun_evt || (overrun_err && !err_clear);
        end
    end

endmodule
